// File: rtl/kv_novf_pkg.sv
// Shared constants for the non-overflowing multi-operand adder.
// CW_OF gives the carry-out width needed so NOP operands can never overflow.
package kv_novf_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // At least one carry bit, even for degenerate operand counts.
  function automatic int CW_OF(input int nop);
    int r;
    r = clog2(nop);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/kv_csa_3to2.sv
// 3:2 carry-save compressor: three addends in, sum vector and shifted carry vector out.
// Purely combinational; the carry vector is pre-shifted so s + c equals x + y + z modulo 2^EW.
module kv_csa_3to2 #(
  parameter int EW = 32
) (
  input  logic [EW-1:0] x,
  input  logic [EW-1:0] y,
  input  logic [EW-1:0] z,
  output logic [EW-1:0] s,
  output logic [EW-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = {(x[EW-2:0] & y[EW-2:0]) | (x[EW-2:0] & z[EW-2:0]) | (y[EW-2:0] & z[EW-2:0]), 1'b0};

endmodule

// File: rtl/kv_novf_adder_pipe.sv
// Two-stage NOP-operand unsigned adder with exact carry-out, wrap/saturate mode and sticky overflow.
// Latency 2 cycles, one result per cycle; valid/ready on both sides, in_ready never depends on in_valid.
module kv_novf_adder_pipe
  import kv_novf_pkg::*;
#(
  parameter int EW  = 32,
  parameter int NOP = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NOP*EW-1:0]     in_ops,
  input  logic                  in_sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EW-1:0]         out_sum,
  output logic [CW_OF(NOP)-1:0] out_carry,
  output logic                  out_ovf,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  localparam int CW = CW_OF(NOP);
  localparam int SW = EW + CW;

  // Stage 1: carry-save reduction at full exact width
  logic [SW-1:0] ops_x   [NOP];
  logic [SW-1:0] s_chain [NOP-1];
  logic [SW-1:0] c_chain [NOP-1];

  for (genvar k = 0; k < NOP; k++) begin : g_ext
    assign ops_x[k] = {{CW{1'b0}}, in_ops[k*EW +: EW]};
  end

  assign s_chain[0] = ops_x[0];
  assign c_chain[0] = ops_x[1];

  for (genvar k = 0; k < NOP - 2; k++) begin : g_csa
    kv_csa_3to2 #(.EW(SW)) u_csa (
      .x (s_chain[k]),
      .y (c_chain[k]),
      .z (ops_x[k+2]),
      .s (s_chain[k+1]),
      .c (c_chain[k+1])
    );
  end

  logic          s1_valid;
  logic          s1_sat;
  logic [SW-1:0] s1_s;
  logic [SW-1:0] s1_c;
  logic          s1_adv;
  logic          in_fire;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       s1_valid <= 1'b0;
    else if (in_fire)  s1_valid <= 1'b1;
    else if (s1_adv)   s1_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_s   <= s_chain[NOP-2];
      s1_c   <= c_chain[NOP-2];
      s1_sat <= in_sat;
    end
  end

  // Stage 2: final carry-propagate add; SW bits hold the exact sum
  logic [SW-1:0] exact;
  logic          ovf_n;
  logic [EW-1:0] sum_n;

  assign exact = s1_s + s1_c;
  assign ovf_n = |exact[SW-1:EW];
  assign sum_n = (s1_sat && ovf_n) ? {EW{1'b1}} : exact[EW-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= '0;
      out_ovf   <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_sum   <= sum_n;
      out_carry <= exact[SW-1:EW];
      out_ovf   <= ovf_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A set on handoff takes priority over a same-cycle clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && out_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)                         ovf_sticky <= 1'b0;
  end

endmodule
